// File: rtl/spm_arbiter_pkg.sv
// spm_arbiter shared definitions: arbiter state encoding,
// master indices and SPM geometry defaults.
package spm_arbiter_pkg;

  localparam int SPM_DATA_W  = 32;
  localparam int SPM_ADDR_W  = 12;
  localparam int ARB_STATE_W = 2;

  typedef enum logic [ARB_STATE_W-1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

endpackage

// File: rtl/spm_arb_next.sv
// Next-owner decision for the SPM port arbiter.
// SPM_ARB_FIXED_PRIO_EN selects strict master-0 priority over round-robin.
module spm_arb_next
  import spm_arbiter_pkg::*;
(
  input  arb_state_e state,
  input  logic       last_owner,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  input  logic [1:0] gnt,
  output arb_state_e next
);

  logic hold0;
  logic hold1;
  logic tie0;

`ifdef SPM_ARB_FIXED_PRIO_EN
  logic unused_rr;
  assign unused_rr = last_owner ^ lock[1] ^ gnt[1];
  assign tie0      = 1'b1;
  // m0 pre-empts an m1 burst after the current beat
  assign hold1     = 1'b0;
`else
  assign tie0      = (last_owner == ARB_M1);
  assign hold1     = gnt[1] & lock[1];
`endif

  assign hold0 = gnt[0] & lock[0];

  always_comb begin
    next = state;
    unique case (state)
      ARB_IDLE: begin
        unique case (1'b1)
          req[0] & req[1]:
            next = tie0 ? ARB_OWN0 : ARB_OWN1;
          req[0] & ~req[1]:
            next = ARB_OWN0;
          ~req[0] & req[1]:
            next = ARB_OWN1;
          default:
            next = ARB_IDLE;
        endcase
      end
      ARB_OWN0: begin
        if (!hold0 && req[1])
          next = ARB_OWN1;
      end
      ARB_OWN1: begin
        if (!hold1 && req[0])
          next = ARB_OWN0;
      end
      default: next = ARB_IDLE;
    endcase
  end

endmodule

// File: rtl/spm_arbiter.sv
// Two-master arbiter in front of SPM port 1 (CPU mem stage vs DMA).
// Build option: SPM_ARB_FIXED_PRIO_EN (see spm_arb_next).
module spm_arbiter
  import spm_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH     = SPM_DATA_W,
  parameter int SPM_ADDR_WIDTH = SPM_ADDR_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      m0_req,
  input  logic                      m0_we,
  input  logic                      m0_lock,
  input  logic [SPM_ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0]     m0_wr_data,
  output logic                      m0_gnt,
  output logic                      m0_rd_valid,
  output logic [DATA_WIDTH-1:0]     m0_rd_data,
  input  logic                      m1_req,
  input  logic                      m1_we,
  input  logic                      m1_lock,
  input  logic [SPM_ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0]     m1_wr_data,
  output logic                      m1_gnt,
  output logic                      m1_rd_valid,
  output logic [DATA_WIDTH-1:0]     m1_rd_data,
  output logic                      spm_we,
  output logic [SPM_ADDR_WIDTH-1:0] spm_addr,
  output logic [DATA_WIDTH-1:0]     spm_wr_data,
  input  logic [DATA_WIDTH-1:0]     spm_rd_data
);

  arb_state_e state;
  arb_state_e state_next;
  logic       last_owner;
  logic       rv0;
  logic       rv1;

  // gating with reset keeps the port quiet in the reset cycle
  assign m0_gnt = ~reset & (state == ARB_OWN0) & m0_req;
  assign m1_gnt = ~reset & (state == ARB_OWN1) & m1_req;

  spm_arb_next u_next (
    .state      (state),
    .last_owner (last_owner),
    .req        ({m1_req, m0_req}),
    .lock       ({m1_lock, m0_lock}),
    .gnt        ({m1_gnt, m0_gnt}),
    .next       (state_next)
  );

  always_comb begin
    spm_we      = 1'b0;
    spm_addr    = '0;
    spm_wr_data = '0;
    unique case (1'b1)
      m0_gnt: begin
        spm_we      = m0_we;
        spm_addr    = m0_addr;
        spm_wr_data = m0_wr_data;
      end
      m1_gnt: begin
        spm_we      = m1_we;
        spm_addr    = m1_addr;
        spm_wr_data = m1_wr_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB_IDLE;
      last_owner <= ARB_M1;
      rv0        <= 1'b0;
      rv1        <= 1'b0;
    end else begin
      state <= state_next;
      if (m0_gnt)
        last_owner <= ARB_M0;
      else if (m1_gnt)
        last_owner <= ARB_M1;
      rv0 <= m0_gnt & ~m0_we;
      rv1 <= m1_gnt & ~m1_we;
    end
  end

  // a read in flight when reset hits is discarded
  assign m0_rd_valid = rv0 & ~reset;
  assign m1_rd_valid = rv1 & ~reset;
  assign m0_rd_data  = spm_rd_data;
  assign m1_rd_data  = spm_rd_data;

endmodule

// File: tb/tb_spm_arbiter.sv
// Self-checking bench for spm_arbiter: directed scenarios plus
// randomized traffic against a rule-level ownership model.
module tb_spm_arbiter;

`ifdef SPM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req, m0_we, m0_lock;
  logic [11:0] m0_addr;
  logic [31:0] m0_wr_data;
  logic        m0_gnt, m0_rd_valid;
  logic [31:0] m0_rd_data;
  logic        m1_req, m1_we, m1_lock;
  logic [11:0] m1_addr;
  logic [31:0] m1_wr_data;
  logic        m1_gnt, m1_rd_valid;
  logic [31:0] m1_rd_data;
  logic        spm_we;
  logic [11:0] spm_addr;
  logic [31:0] spm_wr_data;
  logic [31:0] spm_rd_data = '0;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  spm_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock),
    .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
    .m0_gnt(m0_gnt), .m0_rd_valid(m0_rd_valid), .m0_rd_data(m0_rd_data),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock),
    .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
    .m1_gnt(m1_gnt), .m1_rd_valid(m1_rd_valid), .m1_rd_data(m1_rd_data),
    .spm_we(spm_we), .spm_addr(spm_addr), .spm_wr_data(spm_wr_data),
    .spm_rd_data(spm_rd_data)
  );

  // SPM port 1 with registered read
  logic [31:0] mem [0:4095];
  always @(posedge clk) begin
    if (spm_we) mem[spm_addr] <= spm_wr_data;
    spm_rd_data <= mem[spm_addr];
  end

  // reference model: owner -1 = nobody, else master index
  logic [31:0] ref_mem [0:4095];
  int          owner = -1;
  int          last = 1;
  bit          rv0 = 0, rv1 = 0;
  bit          mg0, mg1, hold;
  logic [31:0] ed0, ed1;

  function automatic bit exp_gnt(input int k);
    if (reset || owner != k) return 1'b0;
    return (k == 0) ? m0_req : m1_req;
  endfunction

  always @(posedge clk) begin : model
    if (reset) begin
      owner = -1; last = 1; rv0 = 0; rv1 = 0;
    end else begin
      mg0 = exp_gnt(0);
      mg1 = exp_gnt(1);
      rv0 = mg0 && !m0_we;
      rv1 = mg1 && !m1_we;
      if (mg0) begin
        if (m0_we) ref_mem[m0_addr] = m0_wr_data;
        else ed0 = ref_mem[m0_addr];
        last = 0;
      end
      if (mg1) begin
        if (m1_we) ref_mem[m1_addr] = m1_wr_data;
        else ed1 = ref_mem[m1_addr];
        last = 1;
      end
      if (owner < 0) begin
        if (m0_req && m1_req) owner = FIXED ? 0 : 1 - last;
        else if (m0_req) owner = 0;
        else if (m1_req) owner = 1;
      end else if (owner == 0) begin
        hold = mg0 && m0_lock;
        if (!hold && m1_req) owner = 1;
      end else begin
        hold = mg1 && m1_lock && !FIXED;
        if (!hold && m0_req) owner = 0;
      end
    end
  end

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wr_data = '0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wr_data = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1; idle_inputs();
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic do_read(input bit k, input logic [11:0] a,
                         output logic [31:0] d, output logic v);
    int lat;
    @(posedge clk); #1;
    if (k) begin m1_req = 1; m1_we = 0; m1_lock = 0; m1_addr = a; end
    else begin m0_req = 1; m0_we = 0; m0_lock = 0; m0_addr = a; end
    lat = 0;
    @(negedge clk);
    while (!(k ? m1_gnt : m0_gnt) && lat < 10) begin
      lat++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    if (k) m1_req = 0; else m0_req = 0;
    @(negedge clk);
    v = k ? m1_rd_valid : m0_rd_valid;
    d = k ? m1_rd_data : m0_rd_data;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1;
    m0_req = 1; m0_we = 1; m0_addr = 12'h005;
    m1_req = 1; m1_we = 1; m1_addr = 12'h006;
    repeat (2) begin
      @(negedge clk);
      n_chk++; if (m0_gnt !== 1'b0) $display("FAIL rst_m0_gnt got=%b exp=0", m0_gnt); else n_pass++;
      n_chk++; if (m1_gnt !== 1'b0) $display("FAIL rst_m1_gnt got=%b exp=0", m1_gnt); else n_pass++;
      n_chk++; if (spm_we !== 1'b0) $display("FAIL rst_spm_we got=%b exp=0", spm_we); else n_pass++;
      n_chk++; if ({m0_rd_valid, m1_rd_valid} !== 2'b00) $display("FAIL rst_rd_valid got=%b exp=00", {m0_rd_valid, m1_rd_valid}); else n_pass++;
      @(posedge clk); #1;
    end
    reset = 0;
    m0_we = 0; m1_req = 0; m1_we = 0;
    @(negedge clk);
    n_chk++; if (m0_gnt !== 1'b0) $display("FAIL idle_no_gnt got=%b exp=0", m0_gnt); else n_pass++;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_single_read();
    do_reset();
    m0_req = 1; m0_we = 0; m0_addr = 12'h010;
    @(negedge clk);
    n_chk++; if (m0_gnt !== 1'b0) $display("FAIL rd_first_cycle_gnt got=%b exp=0", m0_gnt); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++; if (m0_gnt !== 1'b1) $display("FAIL rd_gnt got=%b exp=1", m0_gnt); else n_pass++;
    n_chk++; if (spm_addr !== 12'h010) $display("FAIL rd_spm_addr got=%h exp=010", spm_addr); else n_pass++;
    n_chk++; if (m1_gnt !== 1'b0) $display("FAIL rd_m1_gnt got=%b exp=0", m1_gnt); else n_pass++;
    @(posedge clk); #1;
    m0_req = 0;
    @(negedge clk);
    n_chk++; if (m0_rd_valid !== 1'b1) $display("FAIL rd_valid got=%b exp=1", m0_rd_valid); else n_pass++;
    n_chk++; if (m0_rd_data !== 32'hDEADBEEF) $display("FAIL rd_data got=%h exp=deadbeef", m0_rd_data); else n_pass++;
    n_chk++; if (m1_rd_valid !== 1'b0) $display("FAIL rd_m1_valid got=%b exp=0", m1_rd_valid); else n_pass++;
  endtask

  task automatic test_alternate();
    do_reset();
    m0_req = 1; m0_addr = 12'h010;
    m1_req = 1; m1_addr = 12'h011;
    @(negedge clk);
    n_chk++; if ({m0_gnt, m1_gnt} !== 2'b00) $display("FAIL alt_idle got=%b exp=00", {m0_gnt, m1_gnt}); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_chk++;
      if ({m0_gnt, m1_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
        $display("FAIL alt_beat%0d got=%b exp=%b", i, {m0_gnt, m1_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
      else n_pass++;
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_lock_burst();
    int tr[$];
    int ex[$];
    int b;
    bit g0, g1, done0;
    logic [31:0] d;
    logic v;
    do_reset();
    b = 0; done0 = 0;
    m1_req = 1; m1_we = 1; m1_lock = 1;
    m1_addr = 12'h100; m1_wr_data = 32'hA000_0000;
    for (int c = 0; c < 12 && !(b == 4 && done0); c++) begin
      @(negedge clk);
      g0 = m0_gnt; g1 = m1_gnt;
      tr.push_back(int'(g0) + 2 * int'(g1));
      @(posedge clk); #1;
      if (g1) begin
        b++;
        if (b == 4) m1_req = 0;
        m1_lock = (b < 3);
        m1_addr = 12'h100 + 12'(b);
        m1_wr_data = 32'hA000_0000 + b;
      end
      if (g0) begin done0 = 1; m0_req = 0; end
      if (c == 0) begin m0_req = 1; m0_we = 0; m0_addr = 12'h010; end
    end
    if (FIXED) ex = '{0, 2, 1, 2, 2, 2};
    else ex = '{0, 2, 2, 2, 2, 1};
    n_chk++; if (tr.size() != ex.size()) $display("FAIL burst_len got=%0d exp=%0d", tr.size(), ex.size()); else n_pass++;
    for (int i = 0; i < ex.size(); i++) begin
      n_chk++;
      if (i >= tr.size() || tr[i] != ex[i])
        $display("FAIL burst_cycle%0d got=%0d exp=%0d", i, (i < tr.size()) ? tr[i] : -1, ex[i]);
      else n_pass++;
    end
    for (int i = 0; i < 4; i++) begin
      do_read(1'b0, 12'h100 + 12'(i), d, v);
      n_chk++; if (v !== 1'b1) $display("FAIL burst_rb_valid%0d got=%b exp=1", i, v); else n_pass++;
      n_chk++; if (d !== 32'hA000_0000 + i) $display("FAIL burst_rb_data%0d got=%h exp=%h", i, d, 32'hA000_0000 + i); else n_pass++;
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    m1_req = 1; m1_we = 0; m1_addr = 12'h010;
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++; if (m1_gnt !== 1'b1) $display("FAIL mid_gnt got=%b exp=1", m1_gnt); else n_pass++;
    @(posedge clk); #1;
    reset = 1; m1_we = 1;
    @(negedge clk);
    n_chk++; if (m1_rd_valid !== 1'b0) $display("FAIL mid_rd_valid got=%b exp=0", m1_rd_valid); else n_pass++;
    n_chk++; if (spm_we !== 1'b0) $display("FAIL mid_spm_we got=%b exp=0", spm_we); else n_pass++;
    @(posedge clk); #1;
    reset = 0; m1_we = 0;
    @(negedge clk);
    n_chk++; if (m1_gnt !== 1'b0) $display("FAIL mid_idle_gnt got=%b exp=0", m1_gnt); else n_pass++;
    n_chk++; if (m1_rd_valid !== 1'b0) $display("FAIL mid_post_valid got=%b exp=0", m1_rd_valid); else n_pass++;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_write_read();
    do_reset();
    m0_req = 1; m0_we = 1; m0_addr = 12'h020; m0_wr_data = 32'h0000_55AA;
    @(posedge clk); #1;
    m1_req = 1; m1_we = 0; m1_addr = 12'h020;
    @(negedge clk);
    n_chk++; if (m0_gnt !== 1'b1) $display("FAIL wr_gnt got=%b exp=1", m0_gnt); else n_pass++;
    n_chk++; if (spm_we !== 1'b1) $display("FAIL wr_spm_we got=%b exp=1", spm_we); else n_pass++;
    n_chk++; if (spm_wr_data !== 32'h55AA) $display("FAIL wr_spm_data got=%h exp=55aa", spm_wr_data); else n_pass++;
    @(posedge clk); #1;
    m0_req = 0;
    @(negedge clk);
    n_chk++; if ({m0_gnt, m1_gnt} !== 2'b01) $display("FAIL wr_handover got=%b exp=01", {m0_gnt, m1_gnt}); else n_pass++;
    @(posedge clk); #1;
    m1_req = 0;
    @(negedge clk);
    n_chk++; if (m1_rd_valid !== 1'b1) $display("FAIL wr_rb_valid got=%b exp=1", m1_rd_valid); else n_pass++;
    n_chk++; if (m1_rd_data !== 32'h55AA) $display("FAIL wr_rb_data got=%h exp=55aa", m1_rd_data); else n_pass++;
  endtask

  task automatic test_random();
    bit p0, p1, g0s, g1s, e0, e1;
    logic        ewe;
    logic [11:0] ea;
    logic [31:0] ewd;
    do_reset();
    p0 = 0; p1 = 0; g0s = 0; g1s = 0;
    for (int c = 0; c < 600; c++) begin
      if (p0 && g0s) p0 = 0;
      if (p1 && g1s) p1 = 0;
      if (!p0 && $urandom_range(0, 2) != 0) begin
        p0 = 1; m0_we = 1'($urandom_range(0, 1)); m0_lock = 1'($urandom_range(0, 1));
        m0_addr = 12'h040 + 12'($urandom_range(0, 15)); m0_wr_data = $urandom;
      end else if (p0 && $urandom_range(0, 15) == 0) p0 = 0;
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1; m1_we = 1'($urandom_range(0, 1)); m1_lock = 1'($urandom_range(0, 1));
        m1_addr = 12'h040 + 12'($urandom_range(0, 15)); m1_wr_data = $urandom;
      end else if (p1 && $urandom_range(0, 15) == 0) p1 = 0;
      m0_req = p0; m1_req = p1;
      @(negedge clk);
      e0 = exp_gnt(0); e1 = exp_gnt(1);
      ewe = e0 ? m0_we : (e1 ? m1_we : 1'b0);
      ea  = e0 ? m0_addr : (e1 ? m1_addr : 12'h0);
      ewd = e0 ? m0_wr_data : (e1 ? m1_wr_data : 32'h0);
      n_chk++; if (m0_gnt !== e0) $display("FAIL rnd_m0_gnt c=%0d got=%b exp=%b", c, m0_gnt, e0); else n_pass++;
      n_chk++; if (m1_gnt !== e1) $display("FAIL rnd_m1_gnt c=%0d got=%b exp=%b", c, m1_gnt, e1); else n_pass++;
      n_chk++; if ({spm_we, spm_addr, spm_wr_data} !== {ewe, ea, ewd})
        $display("FAIL rnd_port c=%0d got=%b/%h/%h exp=%b/%h/%h", c, spm_we, spm_addr, spm_wr_data, ewe, ea, ewd);
      else n_pass++;
      n_chk++; if ({m0_rd_valid, m1_rd_valid} !== {rv0, rv1})
        $display("FAIL rnd_rd_valid c=%0d got=%b exp=%b", c, {m0_rd_valid, m1_rd_valid}, {rv0, rv1});
      else n_pass++;
      if (rv0) begin
        n_chk++; if (m0_rd_data !== ed0) $display("FAIL rnd_m0_data c=%0d got=%h exp=%h", c, m0_rd_data, ed0); else n_pass++;
      end
      if (rv1) begin
        n_chk++; if (m1_rd_data !== ed1) $display("FAIL rnd_m1_data c=%0d got=%h exp=%h", c, m1_rd_data, ed1); else n_pass++;
      end
      g0s = m0_gnt; g1s = m1_gnt;
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    mem[16] = 32'hDEADBEEF;
    ref_mem[16] = 32'hDEADBEEF;
    idle_inputs();
    test_reset();
    test_single_read();
    test_alternate();
    test_lock_burst();
    test_reset_mid_read();
    test_write_read();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
